// File: rtl/health_tracker.sv
// health_tracker
//   Tracks hit points, post-hit invulnerability and the "dead" flag for two
//   players.  Every output is a flop, so an input sampled on edge N shows up
//   on the outputs right after edge N.
//
//   Optional feature: define HEALTH_REGEN_EN to give each player a passive
//   regeneration counter (one hp per REGEN_CYCLES quiet cycles).  Without
//   the macro no regen hardware is built.
//
//   Parameters
//     HP_MAX        starting / maximum hp per player (1-15)
//     INVULN_CYCLES length of the post-hit invulnerability window (1-255)
//     REGEN_CYCLES  quiet cycles per regen point (1-65535, regen build only)
//
//   Ports
//     Clk                in   system clock
//     Reset              in   synchronous active-high reset
//     game_reset         in   per-round reinit pulse
//     game_state[1:0]    in   00 menu, 01 playing, 10 game over
//     hit_1, hit_2       in   damage request per player
//     heal_1, heal_2     in   heal pickup per player
//     hp_1, hp_2[3:0]    out  current hit points
//     invuln_1, invuln_2 out  invulnerability window running
//     game_exit          out  player 1 has hit 0 hp (sticky until reset)
//     game_exit_2        out  player 2 has hit 0 hp (sticky until reset)
module health_tracker #(
  parameter logic [3:0] HP_MAX        = 4'd10,
  parameter int         INVULN_CYCLES = 16,
  parameter int         REGEN_CYCLES  = 64
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       game_reset,
  input  logic [1:0] game_state,
  input  logic       hit_1,
  input  logic       hit_2,
  input  logic       heal_1,
  input  logic       heal_2,
  output logic [3:0] hp_1,
  output logic [3:0] hp_2,
  output logic       invuln_1,
  output logic       invuln_2,
  output logic       game_exit,
  output logic       game_exit_2
);

  localparam logic [1:0] GS_PLAYING = 2'b01;
  localparam logic [7:0] INV_LOAD   = INVULN_CYCLES[7:0];

  // Elaboration-time guards on the parameter ranges.
  if (HP_MAX == 4'd0) begin : g_bad_hp
    $error("health_tracker: HP_MAX must be 1-15");
  end
  if (INVULN_CYCLES < 1 || INVULN_CYCLES > 255) begin : g_bad_inv
    $error("health_tracker: INVULN_CYCLES must be 1-255");
  end
  if (REGEN_CYCLES < 1 || REGEN_CYCLES > 65535) begin : g_bad_regen
    $error("health_tracker: REGEN_CYCLES must be 1-65535");
  end

  // Index 0 = player 1, index 1 = player 2.
  logic [3:0] hp_q   [2];
  logic [3:0] hp_d   [2];
  logic [7:0] inv_q  [2];
  logic [7:0] inv_d  [2];
  logic       exit_q [2];
  logic       exit_d [2];

`ifdef HEALTH_REGEN_EN
  localparam logic [15:0] REGEN_LAST = 16'(REGEN_CYCLES - 1);
  logic [15:0] rg_q [2];
  logic [15:0] rg_d [2];
`endif

  logic [1:0] hit;
  logic [1:0] heal;
  logic [1:0] hit_acc;
  logic       playing;

  assign hit     = {hit_2, hit_1};
  assign heal    = {heal_2, heal_1};
  assign playing = (game_state == GS_PLAYING);

  always_comb begin
    hit_acc = '0;
    for (int i = 0; i < 2; i++) begin
      hp_d[i]   = hp_q[i];
      inv_d[i]  = inv_q[i];
      exit_d[i] = exit_q[i];
`ifdef HEALTH_REGEN_EN
      // Regen counter clears unless the count branch below keeps it going.
      rg_d[i]   = '0;
`endif
      if (game_reset) begin
        // Round restart wins over everything and aborts any running window.
        hp_d[i]   = HP_MAX;
        inv_d[i]  = '0;
        exit_d[i] = 1'b0;
      end else begin
        hit_acc[i] = hit[i] && playing && (inv_q[i] == 8'd0) && (hp_q[i] != 4'd0);
        // The window keeps draining even outside the playing state.
        if (inv_q[i] != 8'd0) inv_d[i] = inv_q[i] - 8'd1;

        if (hit_acc[i]) begin
          // An accepted hit swallows a same-cycle heal and any regen point.
          hp_d[i]  = hp_q[i] - 4'd1;
          inv_d[i] = INV_LOAD;
        end else if (heal[i] && playing && (hp_q[i] != 4'd0)) begin
          if (hp_q[i] < HP_MAX) hp_d[i] = hp_q[i] + 4'd1;
        end
`ifdef HEALTH_REGEN_EN
        else if (playing && (hp_q[i] != 4'd0) && (hp_q[i] < HP_MAX)) begin
          if (rg_q[i] == REGEN_LAST) begin
            hp_d[i] = hp_q[i] + 4'd1;
          end else begin
            rg_d[i] = rg_q[i] + 16'd1;
          end
        end
`endif
        // hp can only leave 0 through a reset, so the flag is sticky.
        exit_d[i] = exit_q[i] | (hp_d[i] == 4'd0);
      end
    end
  end

  always_ff @(posedge Clk) begin
    for (int i = 0; i < 2; i++) begin
      if (Reset) begin
        hp_q[i]   <= HP_MAX;
        inv_q[i]  <= '0;
        exit_q[i] <= 1'b0;
`ifdef HEALTH_REGEN_EN
        rg_q[i]   <= '0;
`endif
      end else begin
        hp_q[i]   <= hp_d[i];
        inv_q[i]  <= inv_d[i];
        exit_q[i] <= exit_d[i];
`ifdef HEALTH_REGEN_EN
        rg_q[i]   <= rg_d[i];
`endif
      end
    end
  end

  assign hp_1        = hp_q[0];
  assign hp_2        = hp_q[1];
  assign invuln_1    = (inv_q[0] != 8'd0);
  assign invuln_2    = (inv_q[1] != 8'd0);
  assign game_exit   = exit_q[0];
  assign game_exit_2 = exit_q[1];

endmodule
